bus_dma: RTL and testbench

//  Second bus initiator beside the CPU: a word-copy DMA engine. The CPU programs it through a small

---
 rtl/bus_dma.sv | 190 +++++++++++++++++++
 tb/tb_bus_dma.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma.sv
// bus_dma: word-copy DMA engine. The CPU programs it through a small register window,
// and the engine then masters the system bus to copy LEN words from SRC to DST.
module bus_dma #(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [31:0] m_a,
    output logic [31:0] m_d,
    output logic        m_we,
    output logic        m_rd,
    input  logic [31:0] m_spo,
    input  logic        m_ready,
    output logic        irq
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            state_q;
    logic [31:0]       src_q;
    logic [31:0]       dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [31:0]       buf_q;
    logic [TW-1:0]     tcnt_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              ie_q;
    logic              bus_req_q;
    logic [31:0]       m_a_q;
    logic [31:0]       m_d_q;
    logic              m_we_q;
    logic              m_rd_q;
    logic              irq_q;

    logic wr_src;
    logic wr_dst;
    logic wr_len;
    logic wr_ctrl;
    logic wr_clr;
    logic strobe;

    assign wr_src  = we && (a == 3'd0);
    assign wr_dst  = we && (a == 3'd1);
    assign wr_len  = we && (a == 3'd2);
    assign wr_ctrl = we && (a == 3'd3);
    assign wr_clr  = we && (a == 3'd4);
    assign strobe  = m_rd_q | m_we_q;

    // Register read mux, combinational from the word index.
    always_comb begin
        spo = '0;
        case (a)
            3'd0:    spo = src_q;
            3'd1:    spo = dst_q;
            3'd2:    spo = 32'(len_q);
            3'd3:    spo = {28'b0, err_q, ie_q, done_q, busy_q};
            default: spo = '0;
        endcase
    end

    // Register file and copy FSM; FSM updates are written last so they win over CPU writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            buf_q     <= '0;
            tcnt_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ie_q      <= 1'b0;
            bus_req_q <= 1'b0;
            m_a_q     <= '0;
            m_d_q     <= '0;
            m_we_q    <= 1'b0;
            m_rd_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_q <= done_q & ie_q;
            if (wr_ctrl)         ie_q   <= d[1];
            if (wr_clr && d[0])  done_q <= 1'b0;
            if (wr_clr && d[1])  err_q  <= 1'b0;
            if (!busy_q) begin
                if (wr_src) src_q <= {d[31:2], 2'b00};
                if (wr_dst) dst_q <= {d[31:2], 2'b00};
                if (wr_len) len_q <= d[LEN_W-1:0];
            end

            case (state_q)
                S_IDLE: begin
                    if (wr_ctrl && d[0]) begin
                        if (len_q == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q    <= 1'b1;
                            done_q    <= 1'b0;
                            err_q     <= 1'b0;
                            bus_req_q <= 1'b1;
                            state_q   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_gnt) state_q <= S_RD;
                end
                S_RD, S_WR: begin
                    if (!strobe) begin
                        // Idle cycle between accesses; start the next one once granted.
                        if (bus_gnt) begin
                            tcnt_q <= '0;
                            if (state_q == S_RD) begin
                                m_rd_q <= 1'b1;
                                m_a_q  <= src_q;
                            end else begin
                                m_we_q <= 1'b1;
                                m_a_q  <= dst_q;
                                m_d_q  <= buf_q;
                            end
                        end
                    end else if (!bus_gnt) begin
                        // Grant lost mid-access: back off and retry the same access.
                        m_rd_q <= 1'b0;
                        m_we_q <= 1'b0;
                    end else if (m_ready) begin
                        m_rd_q <= 1'b0;
                        m_we_q <= 1'b0;
                        if (state_q == S_RD) begin
                            buf_q   <= m_spo;
                            state_q <= S_WR;
                        end else begin
                            src_q <= src_q + 32'd4;
                            dst_q <= dst_q + 32'd4;
                            len_q <= len_q - LEN_W'(1);
                            if (len_q == LEN_W'(1)) begin
                                bus_req_q <= 1'b0;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                state_q   <= S_FIN;
                            end else begin
                                state_q <= S_RD;
                            end
                        end
                    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        // This stalled cycle is the TIMEOUT-th one: abort, keep partial progress.
                        err_q     <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        bus_req_q <= 1'b0;
                        m_rd_q    <= 1'b0;
                        m_we_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_req = bus_req_q;
    assign m_a     = m_a_q;
    assign m_d     = m_d_q;
    assign m_we    = m_we_q;
    assign m_rd    = m_rd_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_bus_dma.sv
// tb_bus_dma: directed bench for bus_dma with an arbiter model, a bus responder
// model and a scoreboard of expected read addresses and write address/data pairs.
module tb_bus_dma;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] m_a;
    logic [31:0] m_d;
    logic        m_we;
    logic        m_rd;
    logic [31:0] m_spo;
    logic        m_ready;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Bench knobs shared with the bus models.
    int gnt_delay = 0;
    bit lat_rand = 1'b0;
    int lat_fix = 0;
    int stall_rd = -1;
    int rd_cnt = 0;
    int stall_cyc = 0;
    bit chk_en = 1'b0;
    bit req_seen = 1'b0;

    logic [31:0] ra_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    bus_dma #(.LEN_W(16), .TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .m_a(m_a), .m_d(m_d), .m_we(m_we), .m_rd(m_rd),
        .m_spo(m_spo), .m_ready(m_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memw(input logic [31:0] adr);
        return {adr[15:0], ~adr[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] ra, input logic [31:0] wd);
        @(negedge clk);
        a  = ra;
        d  = wd;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] ra, output logic [31:0] v);
        @(negedge clk);
        a = ra;
        #1 v = spo;
    endtask

    task automatic expect_copy(input logic [31:0] s, input logic [31:0] t, input int n);
        for (int i = 0; i < n; i++) begin
            ra_q.push_back(s + 32'(4 * i));
            wa_q.push_back(t + 32'(4 * i));
            wd_q.push_back(memw(s + 32'(4 * i)));
        end
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        logic [31:0] v;
        n = 0;
        do begin
            rd_reg(3'd3, v);
            n++;
        end while ((v[0] !== 1'b0 || v[1] !== 1'b1) && n < bound);
        chk({tag, "_done_in_time"}, {31'b0, v[1] & ~v[0]}, 32'd1);
    endtask

    // Arbiter model: grants gnt_delay cycles after the request, drops with the request.
    initial begin
        int gcnt;
        gcnt = 0;
        bus_gnt = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_req !== 1'b1) begin
                bus_gnt = 1'b0;
                gcnt = 0;
            end else if (!bus_gnt) begin
                if (gcnt >= gnt_delay) bus_gnt = 1'b1;
                else gcnt++;
            end
        end
    end

    // Bus responder model: checks each access against the scoreboard and answers with m_ready.
    initial begin
        logic [31:0] ea;
        logic [31:0] ed;
        logic strobe;
        bit in_acc;
        bit last_done;
        int wait_cnt;
        int gap;
        in_acc = 1'b0;
        last_done = 1'b0;
        wait_cnt = 0;
        gap = 0;
        m_ready = 1'b0;
        m_spo = '0;
        forever begin
            @(negedge clk);
            strobe = (m_rd === 1'b1) || (m_we === 1'b1);
            if (chk_en) begin
                if (bus_req === 1'b1) req_seen = 1'b1;
                if (strobe) begin
                    chk("strobe_exclusive", {31'b0, m_rd & m_we}, 32'd0);
                    chk("strobe_needs_req_gnt", {30'b0, bus_req, bus_gnt}, 32'd3);
                end
            end
            if (bus_req !== 1'b1) last_done = 1'b0;
            if (m_ready) m_ready = 1'b0;
            if (strobe) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    wait_cnt = lat_rand ? int'($urandom_range(0, 7)) : lat_fix;
                    if (last_done) begin
                        chk("idle_gap", 32'(gap), 32'd1);
                        last_done = 1'b0;
                    end
                    if (m_rd === 1'b1) begin
                        rd_cnt++;
                        if (rd_cnt == stall_rd) stall_cyc = cyc;
                        ea = (ra_q.size() != 0) ? ra_q.pop_front() : 32'hxxxx_xxxx;
                        chk("rd_addr", m_a, ea);
                    end else begin
                        ea = (wa_q.size() != 0) ? wa_q.pop_front() : 32'hxxxx_xxxx;
                        ed = (wd_q.size() != 0) ? wd_q.pop_front() : 32'hxxxx_xxxx;
                        chk("wr_addr", m_a, ea);
                        chk("wr_data", m_d, ed);
                    end
                end
                if (m_rd === 1'b1 && rd_cnt == stall_rd) begin
                    // Stalled read: never answer.
                end else if (wait_cnt == 0) begin
                    if (m_rd === 1'b1) m_spo = memw(m_a);
                    m_ready = 1'b1;
                    in_acc = 1'b0;
                    last_done = 1'b1;
                    gap = 0;
                end else begin
                    wait_cnt--;
                end
            end else begin
                in_acc = 1'b0;
                if (last_done) gap++;
            end
        end
    end

    // Directed test sequence.
    initial begin
        logic [31:0] v;
        int n;
        rst = 1'b1;
        a = '0;
        d = '0;
        we = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_m_rd", {31'b0, m_rd}, 32'd0);
        chk("rst_m_we", {31'b0, m_we}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_m_a", m_a, 32'd0);
        chk("rst_m_d", m_d, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd_reg(3'(i), v);
            chk($sformatf("rst_reg%0d", i), v, 32'd0);
        end

        // 1: basic three-word copy, immediate grant, one-cycle ready.
        expect_copy(32'h1000, 32'h2000, 3);
        wr_reg(3'd0, 32'h1000);
        wr_reg(3'd1, 32'h2000);
        wr_reg(3'd2, 32'd3);
        wr_reg(3'd3, 32'h1);
        wait_idle("t1", 200);
        rd_reg(3'd3, v); chk("t1_stat", v, 32'h2);
        rd_reg(3'd2, v); chk("t1_len", v, 32'd0);
        rd_reg(3'd0, v); chk("t1_src", v, 32'h100C);
        rd_reg(3'd1, v); chk("t1_dst", v, 32'h200C);
        chk("t1_sb_empty", 32'(ra_q.size() + wa_q.size()), 32'd0);

        // 2: zero-length start with IE -> done and irq, no bus request; clear drops irq.
        req_seen = 1'b0;
        wr_reg(3'd2, 32'd0);
        wr_reg(3'd3, 32'h3);
        @(negedge clk);
        chk("t2_irq_set", {31'b0, irq}, 32'd1);
        rd_reg(3'd3, v); chk("t2_stat", v, 32'h6);
        chk("t2_no_bus_req", {31'b0, req_seen}, 32'd0);
        wr_reg(3'd4, 32'h1);
        @(negedge clk);
        chk("t2_irq_clr", {31'b0, irq}, 32'd0);
        wr_reg(3'd3, 32'h0);

        // 3: delayed grant and random ready latency.
        gnt_delay = 20;
        lat_rand = 1'b1;
        expect_copy(32'h3000, 32'h4000, 4);
        wr_reg(3'd0, 32'h3000);
        wr_reg(3'd1, 32'h4000);
        wr_reg(3'd2, 32'd4);
        wr_reg(3'd3, 32'h1);
        wait_idle("t3", 500);
        rd_reg(3'd3, v); chk("t3_stat", v, 32'h2);
        rd_reg(3'd2, v); chk("t3_len", v, 32'd0);
        chk("t3_sb_empty", 32'(ra_q.size() + wa_q.size()), 32'd0);
        gnt_delay = 0;
        lat_rand = 1'b0;
        lat_fix = 0;

        // 4: second read never answered -> timeout abort with partial progress.
        stall_rd = rd_cnt + 2;
        ra_q.push_back(32'h5000);
        ra_q.push_back(32'h5004);
        wa_q.push_back(32'h6000);
        wd_q.push_back(memw(32'h5000));
        wr_reg(3'd0, 32'h5000);
        wr_reg(3'd1, 32'h6000);
        wr_reg(3'd2, 32'd3);
        wr_reg(3'd3, 32'h1);
        n = 0;
        do begin
            rd_reg(3'd3, v);
            n++;
        end while (v[3] !== 1'b1 && n < 1300);
        chk("t4_timeout_cycles", 32'(cyc - stall_cyc), 32'd1023);
        chk("t4_stat", v, 32'hA);
        rd_reg(3'd0, v); chk("t4_src", v, 32'h5004);
        rd_reg(3'd1, v); chk("t4_dst", v, 32'h6004);
        rd_reg(3'd2, v); chk("t4_len", v, 32'd2);
        chk("t4_lines_low", {29'b0, bus_req, m_rd, m_we}, 32'd0);
        chk("t4_sb_empty", 32'(ra_q.size() + wa_q.size()), 32'd0);
        stall_rd = -1;
        wr_reg(3'd4, 32'h3);
        rd_reg(3'd3, v); chk("t4_stat_cleared", v, 32'h0);

        // 5: writes and a second START while busy are ignored.
        gnt_delay = 20;
        expect_copy(32'h7000, 32'h8000, 2);
        wr_reg(3'd0, 32'h7000);
        wr_reg(3'd1, 32'h8000);
        wr_reg(3'd2, 32'd2);
        wr_reg(3'd3, 32'h1);
        rd_reg(3'd3, v); chk("t5_busy", v & 32'h1, 32'h1);
        wr_reg(3'd0, 32'hDEAD);
        wr_reg(3'd3, 32'h1);
        rd_reg(3'd0, v); chk("t5_src_live", v, 32'h7000);
        wait_idle("t5", 300);
        rd_reg(3'd0, v); chk("t5_src", v, 32'h7008);
        rd_reg(3'd1, v); chk("t5_dst", v, 32'h8008);
        rd_reg(3'd3, v); chk("t5_stat", v, 32'h2);
        repeat (5) @(negedge clk);
        chk("t5_no_restart", {31'b0, bus_req}, 32'd0);
        chk("t5_sb_empty", 32'(ra_q.size() + wa_q.size()), 32'd0);
        gnt_delay = 0;

        // 6: reset asserted in the middle of a write access.
        lat_fix = 7;
        expect_copy(32'h9000, 32'hA000, 4);
        wr_reg(3'd0, 32'h9000);
        wr_reg(3'd1, 32'hA000);
        wr_reg(3'd2, 32'd4);
        wr_reg(3'd3, 32'h1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_we !== 1'b1 && n < 100);
        chk("t6_reached_wr", {31'b0, m_we}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_lines_low", {29'b0, bus_req, m_rd, m_we}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_reg(3'(i), v);
            chk($sformatf("t6_reg%0d", i), v, 32'd0);
        end
        ra_q.delete();
        wa_q.delete();
        wd_q.delete();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
